// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle for serial_subtractor; ov exists only with SERIAL_SUB_OVERFLOW_EN
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] d;
  logic bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ov;
  modport master (output start, a, b, bin, input busy, done, d, bout, ov);
  modport slave (input start, a, b, bin, output busy, done, d, bout, ov);
`else
  modport master (output start, a, b, bin, input busy, done, d, bout);
  modport slave (input start, a, b, bin, output busy, done, d, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B-Bin, LSB first, one full-subtractor cell; ov port with SERIAL_SUB_OVERFLOW_EN
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave s
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, sr, sr_n;
  logic [CW-1:0] cnt;
  logic br, dbit, br_n;
  always_comb begin
    dbit = sa[0] ^ sb[0] ^ br;
    br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sr_n = WIDTH'({dbit, sr} >> 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s.busy <= 1'b0;
      s.done <= 1'b0;
      s.d <= '0;
      s.bout <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      s.ov <= 1'b0;
`endif
      cnt <= '0;
      br <= 1'b0;
      sa <= '0;
      sb <= '0;
      sr <= '0;
    end else begin
      s.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (s.start) begin
            sa <= s.a;
            sb <= s.b;
            br <= s.bin;
            sr <= '0;
            cnt <= '0;
            s.busy <= 1'b1;
            state <= RUN;
          end else state <= IDLE;
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sr <= sr_n;
          br <= br_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            s.d <= sr_n;
            s.bout <= br_n;
`ifdef SERIAL_SUB_OVERFLOW_EN
            s.ov <= br ^ br_n;
`endif
            s.busy <= 1'b0;
            s.done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(3)) i3 ();
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .s(i8.slave));
  serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .s(i3.slave));
  always #5 clk = ~clk;

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin, input bit noise, input bit chained);
    int diff;
    logic [7:0] ed;
    logic eb;
`ifdef SERIAL_SUB_OVERFLOW_EN
    int sd;
    logic eov;
    sd = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
    eov = (sd < -128) || (sd > 127);
`endif
    diff = int'(ta) - int'(tb_) - int'(tbin);
    ed = 8'(diff);
    eb = diff < 0;
    if (!chained) @(negedge clk);
    i8.start = 1'b1; i8.a = ta; i8.b = tb_; i8.bin = tbin;
    @(negedge clk);
    i8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i8.busy !== 1'b1 || i8.done !== 1'b0) begin
        failures++;
        $display("FAIL run_flags cyc=%0d busy=%b done=%b want busy=1 done=0", i, i8.busy, i8.done);
      end
      if (noise) begin
        i8.start = 1'b1; i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
      end
      @(negedge clk);
    end
    checks++;
    if (i8.done !== 1'b1 || i8.busy !== 1'b0 || i8.d !== ed || i8.bout !== eb) begin
      failures++;
      $display("FAIL result a=%h b=%h bin=%b got d=%h bout=%b done=%b busy=%b want d=%h bout=%b done=1 busy=0",
               ta, tb_, tbin, i8.d, i8.bout, i8.done, i8.busy, ed, eb);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (i8.ov !== eov) begin
      failures++;
      $display("FAIL ov a=%h b=%h bin=%b got %b want %b", ta, tb_, tbin, i8.ov, eov);
    end
`endif
    i8.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (i8.busy !== 1'b0 || i8.done !== 1'b0 || i8.d !== 8'h00 || i8.bout !== 1'b0) begin
      failures++;
      $display("FAIL reset busy=%b done=%b d=%h bout=%b want all 0", i8.busy, i8.done, i8.d, i8.bout);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    do_op(8'h05, 8'h03, 1'b0, 0, 0);
    do_op(8'h00, 8'h01, 1'b0, 0, 0);
    do_op(8'h10, 8'h0F, 1'b1, 0, 0);
    do_op(8'h80, 8'h01, 1'b0, 0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 0, 0);
    do_op(8'h00, 8'hFF, 1'b1, 0, 0);
    do_op(8'hFF, 8'hFF, 1'b0, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) do_op(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);
  endtask

  task automatic test_back_to_back;
    do_op(8'($urandom), 8'($urandom), 1'($urandom), 1, 0);
    for (int n = 0; n < 10; n++) do_op(8'($urandom), 8'($urandom), 1'($urandom), 1, 1);
    @(negedge clk);
    checks++;
    if (i8.done !== 1'b0 || i8.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle done=%b busy=%b want 0 0", i8.done, i8.busy);
    end
  endtask

  task automatic test_mid_reset;
    bit seen = 0;
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'hA5; i8.b = 8'h3C; i8.bin = 1'b0;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (i8.busy !== 1'b0 || i8.done !== 1'b0 || i8.d !== 8'h00 || i8.bout !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset busy=%b done=%b d=%h bout=%b want all 0", i8.busy, i8.done, i8.d, i8.bout);
    end
    for (int i = 0; i < 12; i++) begin
      if (i8.done !== 1'b0 || i8.busy !== 1'b0) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL aborted_op activity=%b want 0", seen);
    end
    do_op(8'h5A, 8'hC3, 1'b1, 0, 0);
  endtask

  task automatic test_exhaustive_w3;
    for (int ai = 0; ai < 8; ai++)
      for (int bi = 0; bi < 8; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          int diff = ai - bi - ci;
          logic [2:0] ed = 3'(diff);
          logic eb = diff < 0;
          @(negedge clk);
          i3.start = 1'b1; i3.a = 3'(ai); i3.b = 3'(bi); i3.bin = 1'(ci);
          @(negedge clk);
          i3.start = 1'b0;
          repeat (3) @(negedge clk);
          checks++;
          if (i3.done !== 1'b1 || i3.d !== ed || i3.bout !== eb) begin
            failures++;
            $display("FAIL w3 a=%0d b=%0d bin=%0d got d=%0d bout=%b done=%b want d=%0d bout=%b done=1",
                     ai, bi, ci, i3.d, i3.bout, i3.done, ed, eb);
          end
        end
  endtask

  initial begin
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0;
    i3.start = 1'b0; i3.a = '0; i3.b = '0; i3.bin = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_mid_reset;
    test_exhaustive_w3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
